// File: rtl/dpm_carry_ccu_if.sv
// ALU-slice side bundle of the DPM carry/condition-code unit: slice carry terms,
// assembled result and microcode controls in, slice carry-ins and flags out.
interface dpm_carry_ccu_if #(
    parameter int unsigned SLICES = 8
);
    logic [SLICES-1:0]   g_h;
    logic [SLICES-1:0]   p_h;
    logic [SLICES-1:0]   v_h;
    logic [4*SLICES-1:0] aluq_h;
    logic [1:0]          cin_sel_h;
    logic [1:0]          dsize_h;
    logic                cc_load_h;
    logic                cc_chain_h;
    logic                c_save_h;

    logic [SLICES-1:0]   carry_in_h;
    logic                cout_h;
    logic                flag_n_h;
    logic                flag_z_h;
    logic                flag_v_h;
    logic                flag_c_h;
    logic                saved_c_h;

    // Datapath/microcode side drives the slice terms and controls.
    modport master (
        output g_h, p_h, v_h, aluq_h, cin_sel_h, dsize_h, cc_load_h, cc_chain_h, c_save_h,
        input  carry_in_h, cout_h, flag_n_h, flag_z_h, flag_v_h, flag_c_h, saved_c_h
    );

    modport slave (
        input  g_h, p_h, v_h, aluq_h, cin_sel_h, dsize_h, cc_load_h, cc_chain_h, c_save_h,
        output carry_in_h, cout_h, flag_n_h, flag_z_h, flag_v_h, flag_c_h, saved_c_h
    );
endinterface

// File: rtl/dpm_carry_ccu.sv
// Carry-lookahead across the 4-bit ALU slices plus N/Z/V/C and saved-carry registers
// used by multi-precision microcode sequences.
module dpm_carry_ccu #(
    parameter int unsigned SLICES = 8
) (
    input logic            clk_h,
    input logic            reset_h,
    dpm_carry_ccu_if.slave bus
);
    localparam int unsigned WIDTH = 4 * SLICES;

    logic flag_n_q, flag_z_q, flag_v_q, flag_c_q, saved_c_q;
    logic c0;

    // chain[i] is carry into slice i; chain[SLICES] is the full-width carry out.
    logic [SLICES:0] chain;

    always_comb begin
        unique case (bus.cin_sel_h)
            2'd0:    c0 = 1'b0;
            2'd1:    c0 = 1'b1;
            2'd2:    c0 = saved_c_q;
            2'd3:    c0 = flag_c_q;
            default: c0 = 1'b0;
        endcase
    end

    always_comb begin
        chain    = '0;
        chain[0] = c0;
        for (int i = 0; i < SLICES; i++) begin
            chain[i+1] = bus.g_h[i] | (bus.p_h[i] & chain[i]);
        end
    end

    assign bus.carry_in_h = chain[SLICES-1:0];

    logic long_cout, long_v, long_msb, long_zero;
    logic byte_cout, byte_v, byte_msb, byte_zero;
    logic word_cout, word_v, word_msb, word_zero;

    assign long_cout = chain[SLICES];
    assign long_v    = bus.v_h[SLICES-1];
    assign long_msb  = bus.aluq_h[WIDTH-1];
    assign long_zero = ~|bus.aluq_h;

    // Narrow sizes that do not fit in the configured width collapse onto long.
    if (SLICES >= 2) begin : g_byte
        assign byte_cout = chain[2];
        assign byte_v    = bus.v_h[1];
        assign byte_msb  = bus.aluq_h[7];
        assign byte_zero = ~|bus.aluq_h[7:0];
    end else begin : g_byte_long
        assign byte_cout = long_cout;
        assign byte_v    = long_v;
        assign byte_msb  = long_msb;
        assign byte_zero = long_zero;
    end

    if (SLICES >= 4) begin : g_word
        assign word_cout = chain[4];
        assign word_v    = bus.v_h[3];
        assign word_msb  = bus.aluq_h[15];
        assign word_zero = ~|bus.aluq_h[15:0];
    end else begin : g_word_long
        assign word_cout = long_cout;
        assign word_v    = long_v;
        assign word_msb  = long_msb;
        assign word_zero = long_zero;
    end

    logic sel_cout, sel_v, sel_msb, sel_zero;

    always_comb begin
        unique case (bus.dsize_h)
            2'd0: begin
                sel_cout = byte_cout;
                sel_v    = byte_v;
                sel_msb  = byte_msb;
                sel_zero = byte_zero;
            end
            2'd1: begin
                sel_cout = word_cout;
                sel_v    = word_v;
                sel_msb  = word_msb;
                sel_zero = word_zero;
            end
            default: begin
                sel_cout = long_cout;
                sel_v    = long_v;
                sel_msb  = long_msb;
                sel_zero = long_zero;
            end
        endcase
    end

    assign bus.cout_h = sel_cout;

    // Chained Z lets a multi-word result report zero only if every word was zero.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (bus.cc_load_h) begin
            flag_n_q <= sel_msb;
            flag_z_q <= bus.cc_chain_h ? (flag_z_q & sel_zero) : sel_zero;
            flag_v_q <= sel_v;
            flag_c_q <= sel_cout;
        end
    end

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            saved_c_q <= 1'b0;
        end else if (bus.c_save_h) begin
            saved_c_q <= sel_cout;
        end
    end

    assign bus.flag_n_h  = flag_n_q;
    assign bus.flag_z_h  = flag_z_q;
    assign bus.flag_v_h  = flag_v_q;
    assign bus.flag_c_h  = flag_c_q;
    assign bus.saved_c_h = saved_c_q;
endmodule

// File: tb/tb_dpm_carry_ccu.sv
// Directed bench for dpm_carry_ccu: expectations are queued as stimulus is applied and
// checked against the outputs once they are due.
module tb_dpm_carry_ccu;
    localparam int unsigned SLICES = 8;

    logic clk_h;
    logic reset_h;

    dpm_carry_ccu_if #(.SLICES(SLICES)) bus ();

    dpm_carry_ccu #(.SLICES(SLICES)) u_dut (
        .clk_h   (clk_h),
        .reset_h (reset_h),
        .bus     (bus)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    typedef enum logic [2:0] {SigCarry, SigCout, SigN, SigZ, SigV, SigC, SigSaved} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input sig_e sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SigCarry: return 32'(bus.carry_in_h);
            SigCout:  return 32'(bus.cout_h);
            SigN:     return 32'(bus.flag_n_h);
            SigZ:     return 32'(bus.flag_z_h);
            SigV:     return 32'(bus.flag_v_h);
            SigC:     return 32'(bus.flag_c_h);
            default:  return 32'(bus.saved_c_h);
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Registered checks: compare just after the active edge.
    task automatic tick();
        @(posedge clk_h);
        #1;
        drain();
    endtask

    // Combinational checks: let inputs settle mid-cycle.
    task automatic settle();
        #1;
        drain();
    endtask

    task automatic flags(input string tag, input logic n, input logic z, input logic v,
                         input logic c);
        push({tag, "_n"}, SigN, 32'(n));
        push({tag, "_z"}, SigZ, 32'(z));
        push({tag, "_v"}, SigV, 32'(v));
        push({tag, "_c"}, SigC, 32'(c));
    endtask

    task automatic drive(input logic [1:0] cin, input logic [7:0] g, input logic [7:0] p,
                         input logic [7:0] v, input logic [1:0] dsize, input logic [31:0] q);
        bus.cin_sel_h = cin;
        bus.g_h       = g;
        bus.p_h       = p;
        bus.v_h       = v;
        bus.dsize_h   = dsize;
        bus.aluq_h    = q;
    endtask

    task automatic ctrl(input logic load, input logic chain, input logic save);
        bus.cc_load_h  = load;
        bus.cc_chain_h = chain;
        bus.c_save_h   = save;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_h = 1'b0;
        drive(2'd0, 8'h00, 8'h00, 8'h00, 2'd2, 32'h0);
        ctrl(1'b0, 1'b0, 1'b0);

        // Asynchronous reset with no clock edge.
        #2 reset_h = 1'b1;
        flags("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_async_saved", SigSaved, 32'd0);
        settle();

        // Load attempted while reset is held through an edge.
        drive(2'd1, 8'hFF, 8'h00, 8'hFF, 2'd2, 32'h0);
        ctrl(1'b1, 1'b0, 1'b1);
        flags("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_hold_saved", SigSaved, 32'd0);
        tick();
        reset_h = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0);

        // Ripple through every slice.
        drive(2'd1, 8'h00, 8'hFF, 8'h00, 2'd2, 32'h0);
        push("ripple_ci", SigCarry, 32'hFF);
        push("ripple_co", SigCout, 32'd1);
        settle();
        drive(2'd1, 8'h00, 8'h7F, 8'h00, 2'd2, 32'h0);
        push("ripple7f_ci", SigCarry, 32'hFF);
        push("ripple7f_co", SigCout, 32'd0);
        settle();

        // Size-selected carry out.
        drive(2'd0, 8'h02, 8'h00, 8'h00, 2'd0, 32'h0);
        push("byte_ci", SigCarry, 32'h04);
        push("byte_co", SigCout, 32'd1);
        settle();
        bus.dsize_h = 2'd1;
        push("word_co", SigCout, 32'd0);
        settle();
        bus.dsize_h = 2'd2;
        push("long_co", SigCout, 32'd0);
        settle();

        // Size-selected N/Z/V.
        drive(2'd0, 8'h00, 8'h00, 8'h08, 2'd1, 32'hFFFF_0000);
        ctrl(1'b1, 1'b0, 1'b0);
        flags("word_ld", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.dsize_h = 2'd2;
        flags("long_ld", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Multi-precision sequence: low word saves carry, upper words chain Z.
        drive(2'd0, 8'h80, 8'h00, 8'h00, 2'd2, 32'h0);
        ctrl(1'b1, 1'b0, 1'b1);
        flags("mp1", 1'b0, 1'b1, 1'b0, 1'b1);
        push("mp1_saved", SigSaved, 32'd1);
        tick();
        drive(2'd2, 8'h00, 8'h00, 8'h00, 2'd2, 32'h0);
        ctrl(1'b1, 1'b1, 1'b0);
        push("mp2a_ci", SigCarry, 32'h01);
        settle();
        push("mp2a_z", SigZ, 32'd1);
        push("mp2a_c", SigC, 32'd0);
        push("mp2a_saved", SigSaved, 32'd1);
        tick();
        bus.aluq_h = 32'h1;
        push("mp2b_ci", SigCarry, 32'h01);
        settle();
        push("mp2b_z", SigZ, 32'd0);
        tick();
        bus.aluq_h = 32'h0;
        push("mp3_z", SigZ, 32'd0);
        tick();

        // Saved carry feeds the chain and is overwritten on the same edge.
        ctrl(1'b1, 1'b0, 1'b1);
        push("simul_ci", SigCarry, 32'h01);
        push("simul_co", SigCout, 32'd0);
        settle();
        push("simul_saved", SigSaved, 32'd0);
        flags("simul", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Overflow load, then hold with loads disabled.
        drive(2'd0, 8'h80, 8'h00, 8'h80, 2'd2, 32'h0000_0010);
        ctrl(1'b1, 1'b0, 1'b0);
        flags("ovf", 1'b0, 1'b0, 1'b1, 1'b1);
        push("ovf_saved", SigSaved, 32'd0);
        tick();
        drive(2'd0, 8'h00, 8'h00, 8'h00, 2'd2, 32'h8000_0000);
        ctrl(1'b0, 1'b1, 1'b0);
        flags("hold", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        bus.cin_sel_h = 2'd3;
        push("cflag_ci", SigCarry, 32'h01);
        push("cflag_co", SigCout, 32'd0);
        settle();

        // Reset between edges discards saved carry and accumulated Z.
        drive(2'd0, 8'h80, 8'h00, 8'h00, 2'd2, 32'h0);
        ctrl(1'b1, 1'b0, 1'b1);
        push("pre_rst_saved", SigSaved, 32'd1);
        push("pre_rst_z", SigZ, 32'd1);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        #2 reset_h = 1'b1;
        push("mid_rst_saved", SigSaved, 32'd0);
        push("mid_rst_z", SigZ, 32'd0);
        push("mid_rst_c", SigC, 32'd0);
        settle();
        reset_h = 1'b0;
        drive(2'd2, 8'h00, 8'h00, 8'h00, 2'd2, 32'h0);
        push("post_rst_ci", SigCarry, 32'h00);
        settle();
        ctrl(1'b1, 1'b1, 1'b0);
        push("post_rst_chain_z", SigZ, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
